// File: rtl/lcd_pkg.sv
// Shared constants, FSM state type and DDRAM row-base lookup for the LCD text writer.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic       LCD_ADDR_CMD      = 1'b0;
    localparam logic       LCD_ADDR_DATA     = 1'b1;
    localparam logic [7:0] LCD_BLANK         = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SET_POS,
        ST_CHAR,
        ST_GAP,
        ST_FINISH
    } lcd_state_t;

    // Rows 2 and 3 of 4-line panels continue rows 0 and 1 after COLS characters.
    function automatic logic [7:0] row_base(input logic [1:0] row, input int cols);
        case (row)
            2'd0:    row_base = 8'h00;
            2'd1:    row_base = 8'h40;
            2'd2:    row_base = 8'(cols);
            default: row_base = 8'(8'h40 + cols);
        endcase
    endfunction

endpackage

// File: rtl/lcd_av_write.sv
// Single Avalon-MM write transfer: registered outputs held through waitrequest,
// ack on the completing edge, forced idle cycle after every transfer.
module lcd_av_write
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       is_data,
    input  logic [7:0] byte_val,
    input  logic       waitrequest,
    output logic       ack,
    output logic       address,
    output logic       chipselect,
    output logic       write,
    output logic [7:0] writedata
);

    always_ff @(posedge clk) begin
        if (reset) begin
            address    <= 1'b0;
            chipselect <= 1'b0;
            write      <= 1'b0;
            writedata  <= 8'h00;
        end else if (write) begin
            if (!waitrequest) begin
                chipselect <= 1'b0;
                write      <= 1'b0;
            end
        end else if (go) begin
            // go is ignored while a transfer is up, which yields the idle gap cycle.
            address    <= is_data ? LCD_ADDR_DATA : LCD_ADDR_CMD;
            chipselect <= 1'b1;
            write      <= 1'b1;
            writedata  <= byte_val;
        end
    end

    assign ack = write & ~waitrequest;

endmodule

// File: rtl/lcd_text_writer.sv
// COLS x ROWS character frame buffer streamed to the LCD_IP Avalon slave on request;
// first write one cycle after refresh, waitrequest stalls freely, refreshes during a pass coalesce.
module lcd_text_writer
    import lcd_pkg::*;
#(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter bit CLEAR_FIRST = 1'b0,
    parameter int AW          = $clog2(COLS*ROWS)
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          buf_we,
    input  logic [AW-1:0] buf_addr,
    input  logic [7:0]    buf_wdata,
    input  logic          refresh,
    output logic          busy,
    output logic          done,
    output logic          address,
    output logic          chipselect,
    output logic          write,
    output logic          read,
    output logic [7:0]    writedata,
    input  logic          waitrequest
);

    localparam int DEPTH = COLS * ROWS;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [IW-1:0] waddr;
    logic [IW-1:0] idx;
    logic          waddr_ok;
    logic [7:0]    char_byte;

    lcd_state_t state, state_n, ret, ret_n;
    logic [1:0] row, row_n;
    logic [4:0] col, col_n;
    logic       pending, pending_n;
    logic       start;
    logic       go, go_data, ack;
    logic [7:0] go_byte;

    assign waddr    = IW'(buf_addr);
    assign waddr_ok = int'(buf_addr) < DEPTH;
    assign idx      = IW'(int'(row) * COLS + int'(col));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= LCD_BLANK;
        end else if (buf_we && waddr_ok) begin
            mem[waddr] <= buf_wdata;
        end
    end

    // Forward a same-cycle write so the byte matches the buffer when the transfer appears.
    assign char_byte = (buf_we && waddr_ok && waddr == idx) ? buf_wdata : mem[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ret     <= ST_IDLE;
            row     <= 2'd0;
            col     <= 5'd0;
            pending <= 1'b0;
        end else begin
            state   <= state_n;
            ret     <= ret_n;
            row     <= row_n;
            col     <= col_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        state_n   = state;
        ret_n     = ret;
        row_n     = row;
        col_n     = col;
        pending_n = pending | (refresh && state != ST_IDLE);
        start     = 1'b0;
        go        = 1'b0;
        go_data   = 1'b0;
        go_byte   = 8'h00;
        case (state)
            ST_IDLE, ST_FINISH: begin
                start = (state == ST_IDLE) ? (refresh | pending) : pending;
                if (start) begin
                    row_n     = 2'd0;
                    col_n     = 5'd0;
                    pending_n = (state == ST_FINISH) && refresh;
                    go        = 1'b1;
                    if (CLEAR_FIRST) begin
                        go_byte = LCD_CMD_CLEAR;
                        state_n = ST_CLEAR;
                    end else begin
                        go_byte = LCD_CMD_SET_DDRAM | row_base(2'd0, COLS);
                        state_n = ST_SET_POS;
                    end
                end else if (state == ST_FINISH) begin
                    state_n = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (ack) begin
                    ret_n   = ST_SET_POS;
                    state_n = ST_GAP;
                end
            end
            ST_SET_POS: begin
                if (ack) begin
                    ret_n   = ST_CHAR;
                    state_n = ST_GAP;
                end
            end
            ST_CHAR: begin
                if (ack) begin
                    state_n = ST_GAP;
                    if (int'(col) < COLS - 1) begin
                        col_n = col + 5'd1;
                        ret_n = ST_CHAR;
                    end else if (int'(row) < ROWS - 1) begin
                        row_n = row + 2'd1;
                        col_n = 5'd0;
                        ret_n = ST_SET_POS;
                    end else begin
                        ret_n = ST_FINISH;
                    end
                end
            end
            ST_GAP: begin
                state_n = ret;
                if (ret == ST_SET_POS) begin
                    go      = 1'b1;
                    go_byte = LCD_CMD_SET_DDRAM | row_base(row, COLS);
                end else if (ret == ST_CHAR) begin
                    go      = 1'b1;
                    go_data = 1'b1;
                    go_byte = char_byte;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    lcd_av_write u_av_write (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .is_data     (go_data),
        .byte_val    (go_byte),
        .waitrequest (waitrequest),
        .ack         (ack),
        .address     (address),
        .chipselect  (chipselect),
        .write       (write),
        .writedata   (writedata)
    );

    assign busy = (state != ST_IDLE) && (state != ST_FINISH);
    assign done = (state == ST_FINISH);
    assign read = 1'b0;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Randomised bench for lcd_text_writer: a 16x2 instance behind a stalling slave model
// and a CLEAR_FIRST instance with a zero-wait slave, both checked against a frame model.
module tb_lcd_text_writer;

    logic       clk, reset, buf_we, refresh;
    logic [5:0] buf_addr;
    logic [7:0] buf_wdata;

    logic       busy, done, address, chipselect, write, read, waitrequest;
    logic [7:0] writedata;
    logic       b_busy, b_done, b_address, b_chipselect, b_write, b_read;
    logic [7:0] b_writedata;
    logic       b_waitrequest;

    int checks = 0;
    int fails  = 0;

    logic [7:0] model [32];
    logic [8:0] qa [$];
    logic [8:0] qb [$];
    logic [8:0] exp_q [$];

    int         stall_mode = 0;
    logic [3:0] stall_cnt = 4'd0;

    lcd_text_writer #(.COLS(16), .ROWS(2), .CLEAR_FIRST(1'b0), .AW(6)) dut (
        .clk(clk), .reset(reset), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .refresh(refresh), .busy(busy), .done(done), .address(address), .chipselect(chipselect),
        .write(write), .read(read), .writedata(writedata), .waitrequest(waitrequest)
    );

    lcd_text_writer #(.COLS(16), .ROWS(2), .CLEAR_FIRST(1'b1), .AW(6)) dut_clr (
        .clk(clk), .reset(reset), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .refresh(refresh), .busy(b_busy), .done(b_done), .address(b_address), .chipselect(b_chipselect),
        .write(b_write), .read(b_read), .writedata(b_writedata), .waitrequest(b_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign b_waitrequest = 1'b0;
    assign waitrequest = (stall_mode == 2) || (stall_mode == 1 && write && stall_cnt < 4'd3);

    always @(posedge clk) stall_cnt <= (write && waitrequest) ? stall_cnt + 4'd1 : 4'd0;

    // A transfer seen with write high and waitrequest low completes on the next edge.
    always @(negedge clk) begin
        if (!reset && write && chipselect && !waitrequest) qa.push_back({address, writedata});
        if (!reset && b_write && b_chipselect) qb.push_back({b_address, b_writedata});
    end

    task automatic write_char(input int a, input logic [7:0] d);
        buf_we = 1'b1; buf_addr = 6'(a); buf_wdata = d;
        @(negedge clk);
        buf_we = 1'b0;
        if (a < 32) model[a] = d;
    endtask

    task automatic build_exp(input bit cf);
        exp_q.delete();
        if (cf) exp_q.push_back({1'b0, 8'h01});
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back({1'b0, (r == 0) ? 8'h80 : 8'hC0});
            for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, model[r*16 + c]});
        end
    endtask

    task automatic do_pass(input bit use_b, output int cycles);
        qa.delete(); qb.delete();
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
        cycles = -1;
        for (int n = 1; n <= 2000; n++) begin
            if ((use_b ? b_done : done) === 1'b1) begin cycles = n; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int cyc;
        reset = 1'b1; buf_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            buf_addr = 6'($urandom_range(0, 31)); buf_wdata = 8'($urandom);
            @(negedge clk);
            checks++;
            if ({busy, done, chipselect, write, read, address, writedata} !== 14'd0) begin
                fails++;
                $display("FAIL reset_outputs got busy=%b done=%b cs=%b wr=%b rd=%b addr=%b wd=%h want all 0",
                         busy, done, chipselect, write, read, address, writedata);
            end
        end
        reset = 1'b0; buf_we = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        @(negedge clk);
        do_pass(1'b0, cyc);
        build_exp(1'b0);
        checks++;
        if (qa.size() != exp_q.size()) begin fails++; $display("FAIL reset_pass_count got %0d want %0d", qa.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= qa.size() || qa[i] !== exp_q[i]) begin fails++; $display("FAIL reset_pass_xfer%0d got %h want %h", i, (i < qa.size()) ? qa[i] : 9'h0, exp_q[i]); end
        end
    endtask

    task automatic test_hello;
        int cyc;
        string s1 = "HELLO", s2 = "WORLD";
        repeat (10) @(negedge clk);
        for (int i = 0; i < 5; i++) write_char(i, s1[i]);
        for (int i = 0; i < 5; i++) write_char(16 + i, s2[i]);
        do_pass(1'b0, cyc);
        build_exp(1'b0);
        checks++;
        if (cyc != 69) begin fails++; $display("FAIL hello_done_latency got %0d want 69", cyc); end
        checks++;
        if (qa.size() != 34 || qa[1] !== 9'h148 || qa[17] !== 9'h0C0 || qa[18] !== 9'h157) begin
            fails++; $display("FAIL hello_key_bytes got n=%0d %h %h %h want 34 148 0c0 157", qa.size(), qa[1], qa[17], qa[18]);
        end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= qa.size() || qa[i] !== exp_q[i]) begin fails++; $display("FAIL hello_xfer%0d got %h want %h", i, (i < qa.size()) ? qa[i] : 9'h0, exp_q[i]); end
        end
    endtask

    task automatic test_stall;
        int n, xfers;
        bit got;
        logic pw, pq, pa;
        logic [7:0] pd;
        repeat (10) @(negedge clk);
        stall_mode = 1;
        qa.delete();
        refresh = 1'b1; @(negedge clk); refresh = 1'b0;
        pw = 1'b0; pq = 1'b0; pa = 1'b0; pd = 8'h00; xfers = 0; got = 1'b0;
        for (n = 1; n <= 400; n++) begin
            if (pw && pq) begin
                checks++;
                if (write !== 1'b1 || chipselect !== 1'b1 || address !== pa || writedata !== pd) begin
                    fails++; $display("FAIL stall_hold cyc%0d got wr=%b cs=%b a=%b d=%h want 1 1 %b %h", n, write, chipselect, address, writedata, pa, pd);
                end
            end
            if (pw && !pq) begin
                checks++;
                if (write !== 1'b0 || chipselect !== 1'b0) begin
                    fails++; $display("FAIL stall_gap cyc%0d got wr=%b cs=%b want 0 0", n, write, chipselect);
                end
            end
            if (write && !waitrequest) xfers++;
            if (done === 1'b1) begin got = 1'b1; break; end
            pw = write; pq = waitrequest; pa = address; pd = writedata;
            @(negedge clk);
        end
        checks++;
        if (!got || n != 171) begin fails++; $display("FAIL stall_done_latency got %0d want 171", got ? n : -1); end
        checks++;
        if (xfers != 34) begin fails++; $display("FAIL stall_xfer_count got %0d want 34", xfers); end
        build_exp(1'b0);
        foreach (exp_q[i]) begin
            checks++;
            if (i >= qa.size() || qa[i] !== exp_q[i]) begin fails++; $display("FAIL stall_xfer%0d got %h want %h", i, (i < qa.size()) ? qa[i] : 9'h0, exp_q[i]); end
        end
        stall_mode = 0;
    endtask

    task automatic test_back_to_back;
        int dones, lows, d1, d2;
        repeat (10) @(negedge clk);
        qa.delete();
        refresh = 1'b1; @(negedge clk); refresh = 1'b0;
        dones = 0; lows = 0; d1 = -1; d2 = -1;
        for (int n = 1; n <= 400; n++) begin
            refresh = (n == 5 || n == 20 || n == 40);
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) d1 = n;
                if (dones == 2) d2 = n;
            end
            if (busy !== 1'b1 && dones < 2) lows++;
            @(negedge clk);
        end
        refresh = 1'b0;
        checks++;
        if (dones != 2) begin fails++; $display("FAIL b2b_done_pulses got %0d want 2", dones); end
        checks++;
        if (d1 != 69 || d2 != 138) begin fails++; $display("FAIL b2b_done_times got %0d,%0d want 69,138", d1, d2); end
        checks++;
        if (lows != 1) begin fails++; $display("FAIL b2b_busy_low got %0d want 1", lows); end
        checks++;
        if (qa.size() != 68) begin fails++; $display("FAIL b2b_xfer_count got %0d want 68", qa.size()); end
    endtask

    task automatic test_midpass;
        int cyc;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) write_char($urandom_range(0, 30), 8'($urandom_range(33, 126)));
        fork
            do_pass(1'b0, cyc);
            begin
                repeat (5) @(negedge clk);
                write_char($urandom_range(40, 63), 8'($urandom_range(33, 126)));
                repeat (3) @(negedge clk);
                write_char(31, 8'h5A);
            end
        join
        build_exp(1'b0);
        checks++;
        if (cyc != 69) begin fails++; $display("FAIL midpass_done_latency got %0d want 69", cyc); end
        checks++;
        if (qa.size() != 34 || qa[33] !== 9'h15A) begin fails++; $display("FAIL midpass_last_byte got %h want 15a", qa[qa.size()-1]); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= qa.size() || qa[i] !== exp_q[i]) begin fails++; $display("FAIL midpass_xfer%0d got %h want %h", i, (i < qa.size()) ? qa[i] : 9'h0, exp_q[i]); end
        end
    endtask

    task automatic test_clear_first;
        int cyc;
        repeat (10) @(negedge clk);
        do_pass(1'b1, cyc);
        build_exp(1'b1);
        checks++;
        if (cyc != 71) begin fails++; $display("FAIL clear_done_latency got %0d want 71", cyc); end
        checks++;
        if (qb.size() != 35 || qb[0] !== 9'h001) begin fails++; $display("FAIL clear_first_xfer got n=%0d %h want 35 001", qb.size(), qb[0]); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= qb.size() || qb[i] !== exp_q[i]) begin fails++; $display("FAIL clear_xfer%0d got %h want %h", i, (i < qb.size()) ? qb[i] : 9'h0, exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        repeat (10) @(negedge clk);
        stall_mode = 2;
        refresh = 1'b1; @(negedge clk); refresh = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (write !== 1'b1 || waitrequest !== 1'b1) begin fails++; $display("FAIL rmid_stalled got wr=%b wait=%b want 1 1", write, waitrequest); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (write !== 1'b0 || chipselect !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL rmid_drop got wr=%b cs=%b busy=%b want 0 0 0", write, chipselect, busy);
        end
        reset = 1'b0; stall_mode = 0;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        repeat (2) @(negedge clk);
        do_pass(1'b0, cyc);
        build_exp(1'b0);
        checks++;
        if (cyc != 69) begin fails++; $display("FAIL rmid_done_latency got %0d want 69", cyc); end
        checks++;
        if (qa.size() != 34) begin fails++; $display("FAIL rmid_xfer_count got %0d want 34", qa.size()); end
        foreach (exp_q[i]) begin
            checks++;
            if (i >= qa.size() || qa[i] !== exp_q[i]) begin fails++; $display("FAIL rmid_xfer%0d got %h want %h", i, (i < qa.size()) ? qa[i] : 9'h0, exp_q[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; buf_we = 1'b0; buf_addr = 6'd0; buf_wdata = 8'h00; refresh = 1'b0;
        test_reset();
        test_hello();
        test_stall();
        test_back_to_back();
        test_midpass();
        test_clear_first();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
